// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared CPU front-end definitions: reset vector, bubble encoding and fetch FSM states.
// Also holds the sequential-fetch increment used by the next-PC mux.
package fetch_redirect_ctrl_pkg;

   localparam logic [31:0] CPU_RESET_PC   = 32'hBFC0_0000;
   localparam logic [31:0] CPU_NOP_INSTR  = 32'h0000_0000;
   localparam int          CPU_MAX_SQUASH = 3;

   typedef logic [0:0] fetch_state_t;
   localparam fetch_state_t ST_RUN    = 1'b0;
   localparam fetch_state_t ST_SQUASH = 1'b1;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux plus the held-redirect register used when a target
// arrives while the PC is stalled.
module pc_next_sel
   import fetch_redirect_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_wr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] pc,
   output logic [31:0] pc_next
);

   logic [31:0] tgt_q;
   logic        tgt_pend;

   always_comb begin
      pc_next = pc;
      if (redirect_valid && pc_wr) begin
         pc_next = redirect_pc;
      end else if (redirect_valid) begin
         pc_next = pc;
      end else if (tgt_pend && pc_wr) begin
         pc_next = tgt_q;
      end else if (pc_wr) begin
         pc_next = pc_plus4(pc);
      end
   end

   // A fresh redirect always supersedes a held one, whether it is taken now or held.
   always_ff @(posedge clk) begin
      if (rst) begin
         tgt_q    <= '0;
         tgt_pend <= 1'b0;
      end else if (redirect_valid) begin
         tgt_q    <= redirect_pc;
         tgt_pend <= ~pc_wr;
      end else if (tgt_pend && pc_wr) begin
         tgt_pend <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-side consumer of the hazard unit: PC register, IF/ID register and the
// squash FSM that inserts bubbles until a control-transfer target arrives.
module fetch_redirect_ctrl
   import fetch_redirect_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = CPU_RESET_PC,
   parameter int          MAX_SQUASH = CPU_MAX_SQUASH,
   parameter logic [31:0] NOP_INSTR  = CPU_NOP_INSTR
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_wr,
   input  logic        ir_wr,
   input  logic        nop,
   input  logic        nop_imme,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] imem_rdata,
   output logic [31:0] imem_addr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_ir,
   output logic        if_id_valid,
   output logic        nop_r,
   output logic        squash_err
);

   localparam int                CNT_W    = $clog2(MAX_SQUASH) + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_SQUASH - 1);

   logic [31:0]      pc;
   logic [31:0]      pc_next;
   fetch_state_t     state;
   logic [CNT_W-1:0] squash_cnt;
   logic             squash_pend;
   logic             load_bubble;

   pc_next_sel u_pc_next_sel (
      .clk            (clk),
      .rst            (rst),
      .pc_wr          (pc_wr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc             (pc),
      .pc_next        (pc_next)
   );

   assign imem_addr   = pc;
   assign load_bubble = (state == ST_SQUASH) || nop || squash_pend;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         nop_r <= 1'b0;
      end else begin
         pc    <= pc_next;
         nop_r <= nop & ~nop_imme;
      end
   end

   // A nop that lands while IF/ID is frozen is remembered so the squash still happens.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_id_pc    <= '0;
         if_id_ir    <= NOP_INSTR;
         if_id_valid <= 1'b0;
         squash_pend <= 1'b0;
      end else if (!ir_wr) begin
         if (nop) begin
            squash_pend <= 1'b1;
         end
      end else if (load_bubble) begin
         if_id_pc    <= pc;
         if_id_ir    <= NOP_INSTR;
         if_id_valid <= 1'b0;
         squash_pend <= 1'b0;
      end else begin
         if_id_pc    <= pc;
         if_id_ir    <= imem_rdata;
         if_id_valid <= 1'b1;
      end
   end

   // The redirect cycle itself still loads a bubble; fetch from the target starts next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_RUN;
         squash_cnt <= '0;
         squash_err <= 1'b0;
      end else if (state == ST_SQUASH) begin
         if (redirect_valid) begin
            state <= ST_RUN;
         end else if (squash_cnt == CNT_LAST) begin
            state      <= ST_RUN;
            squash_err <= 1'b1;
         end else begin
            squash_cnt <= squash_cnt + 1'b1;
         end
      end else if (ir_wr && nop && !redirect_valid) begin
         state      <= ST_SQUASH;
         squash_cnt <= '0;
      end
   end

endmodule
